condicionador_botoes: RTL and testbench

Pedestrian push-button conditioner for the two-approach crossing, sitting between the raw GPIO button pins and the crossing controller's pedestrian request inputs. Each of the two channels (A, B) does three things:
- synchronises the raw pin to clk;
- debounces it;
- turns each debounced press into a latched pedestrian request that stays set until the controller acknowledges it.

It also drives a "wait" indicator per channel.

---
 rtl/condicionador_botoes_pkg.sv | 22 ++
 rtl/condicionador_botoes_if.sv | 30 +++
 rtl/condicionador_botoes_canal_botao.sv | 125 ++++++++++++
 rtl/condicionador_botoes.sv | 65 ++++++
 tb/tb_condicionador_botoes.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the pedestrian push-button conditioner:
// debounce state encoding, default timing constants and a counter-width helper.
package condicionador_botoes_pkg;

   typedef enum logic [1:0] {
      SOLTO       = 2'd0,
      CONF_PRESS  = 2'd1,
      PRESSIONADO = 2'd2,
      CONF_SOLTA  = 2'd3
   } estado_deb_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned LOCKOUT_CYCLES_DEF  = 8;
   localparam bit          ATIVO_BAIXO_DEF     = 1'b1;

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int unsigned largura_cnt(input int unsigned max_val);
      if (max_val == 0) return 1;
      return 32'($clog2(max_val + 1));
   endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Button-side and controller-side signals of the conditioner, bundled for port use.
interface condicionador_botoes_if;

   logic botao_A_raw;
   logic botao_B_raw;
   logic ack_A;
   logic ack_B;
   logic clk_blinker;
   logic botao_A;
   logic botao_B;
   logic pulso_A;
   logic pulso_B;
   logic pedido_A;
   logic pedido_B;
   logic led_espera_A;
   logic led_espera_B;

   modport master (
      output botao_A_raw, botao_B_raw, ack_A, ack_B, clk_blinker,
      input  botao_A, botao_B, pulso_A, pulso_B, pedido_A, pedido_B,
             led_espera_A, led_espera_B
   );

   modport slave (
      input  botao_A_raw, botao_B_raw, ack_A, ack_B, clk_blinker,
      output botao_A, botao_B, pulso_A, pulso_B, pedido_A, pedido_B,
             led_espera_A, led_espera_B
   );

endinterface

// File: rtl/condicionador_botoes_canal_botao.sv
// One button channel: polarity fix, 2-FF synchroniser, debounce FSM,
// press pulse, latched request and post-ack lockout.
module canal_botao
   import condicionador_botoes_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
   parameter bit          ATIVO_BAIXO     = ATIVO_BAIXO_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic botao_raw,
   input  logic ack,
   output logic botao,
   output logic pulso,
   output logic pedido
);

   localparam int unsigned CW = largura_cnt(DEBOUNCE_CYCLES);
   localparam int unsigned LW = largura_cnt(LOCKOUT_CYCLES);
   localparam logic [CW-1:0] CNT_FIM  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_INI = LW'(LOCKOUT_CYCLES);

   logic          nivel;
   logic          s1, s2;
   estado_deb_t   estado, estado_prox;
   logic [CW-1:0] cnt, cnt_prox;
   logic          botao_prox, pulso_prox;
   logic [LW-1:0] lock_cnt;
   logic          lockout_ativo;
   logic          aceita;

   // Normalise to 1 = pressed before synchronising.
   assign nivel = ATIVO_BAIXO ? ~botao_raw : botao_raw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= nivel;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado <= SOLTO;
         cnt    <= '0;
         botao  <= 1'b0;
         pulso  <= 1'b0;
      end else begin
         estado <= estado_prox;
         cnt    <= cnt_prox;
         botao  <= botao_prox;
         pulso  <= pulso_prox;
      end
   end

   // A level must hold DEBOUNCE_CYCLES samples in a row to be accepted.
   always_comb begin
      estado_prox = estado;
      cnt_prox    = cnt;
      case (estado)
         SOLTO: begin
            if (s2) begin
               estado_prox = CONF_PRESS;
               cnt_prox    = CW'(1);
            end
         end
         CONF_PRESS: begin
            if (!s2) begin
               estado_prox = SOLTO;
               cnt_prox    = '0;
            end else if (cnt == CNT_FIM) begin
               estado_prox = PRESSIONADO;
               cnt_prox    = '0;
            end else begin
               cnt_prox = cnt + CW'(1);
            end
         end
         PRESSIONADO: begin
            if (!s2) begin
               estado_prox = CONF_SOLTA;
               cnt_prox    = CW'(1);
            end
         end
         CONF_SOLTA: begin
            if (s2) begin
               estado_prox = PRESSIONADO;
               cnt_prox    = '0;
            end else if (cnt == CNT_FIM) begin
               estado_prox = SOLTO;
               cnt_prox    = '0;
            end else begin
               cnt_prox = cnt + CW'(1);
            end
         end
         default: begin
            estado_prox = SOLTO;
            cnt_prox    = '0;
         end
      endcase
      botao_prox = (estado_prox == PRESSIONADO) || (estado_prox == CONF_SOLTA);
      pulso_prox = (estado == CONF_PRESS) && (estado_prox == PRESSIONADO);
   end

   assign lockout_ativo = (lock_cnt != '0);
   assign aceita        = pulso && !lockout_ativo;

   // Accepted press beats a simultaneous ack; only a consumed request arms the lockout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pedido   <= 1'b0;
         lock_cnt <= '0;
      end else begin
         if (aceita)   pedido <= 1'b1;
         else if (ack) pedido <= 1'b0;

         if (ack && pedido)       lock_cnt <= LOCK_INI;
         else if (lockout_ativo)  lock_cnt <= lock_cnt - LW'(1);
      end
   end

endmodule

// File: rtl/condicionador_botoes.sv
// Two-channel pedestrian button conditioner with blink-gated wait LEDs.
module condicionador_botoes
   import condicionador_botoes_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
   parameter bit          ATIVO_BAIXO     = ATIVO_BAIXO_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   condicionador_botoes_if.slave bus
);

   logic botao_a, botao_b, pulso_a, pulso_b, pedido_a, pedido_b;
   logic blink_s1, blink_s;

   canal_botao #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
      .ATIVO_BAIXO     (ATIVO_BAIXO)
   ) u_canal_a (
      .clk       (clk),
      .reset     (reset),
      .botao_raw (bus.botao_A_raw),
      .ack       (bus.ack_A),
      .botao     (botao_a),
      .pulso     (pulso_a),
      .pedido    (pedido_a)
   );

   canal_botao #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
      .ATIVO_BAIXO     (ATIVO_BAIXO)
   ) u_canal_b (
      .clk       (clk),
      .reset     (reset),
      .botao_raw (bus.botao_B_raw),
      .ack       (bus.ack_B),
      .botao     (botao_b),
      .pulso     (pulso_b),
      .pedido    (pedido_b)
   );

   // The blink source is asynchronous data, so it gets its own synchroniser.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_s1 <= 1'b0;
         blink_s  <= 1'b0;
      end else begin
         blink_s1 <= bus.clk_blinker;
         blink_s  <= blink_s1;
      end
   end

   assign bus.botao_A      = botao_a;
   assign bus.botao_B      = botao_b;
   assign bus.pulso_A      = pulso_a;
   assign bus.pulso_B      = pulso_b;
   assign bus.pedido_A     = pedido_a;
   assign bus.pedido_B     = pedido_b;
   assign bus.led_espera_A = pedido_a & blink_s;
   assign bus.led_espera_B = pedido_b & blink_s;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: two instances (lockout 8 and 0), directed table,
// hand-written corner sequences and random stimulus against a run-length reference model.
module tb_condicionador_botoes;
   import condicionador_botoes_pkg::*;

   localparam int unsigned DEB = 4;
   localparam int unsigned NVEC = 16;

   logic clk = 1'b0;
   logic reset;
   logic raw_a, raw_b, ack_a, ack_b, blink;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   condicionador_botoes_if bus0 ();
   condicionador_botoes_if bus1 ();

   assign bus0.botao_A_raw = raw_a;
   assign bus0.botao_B_raw = raw_b;
   assign bus0.ack_A       = ack_a;
   assign bus0.ack_B       = ack_b;
   assign bus0.clk_blinker = blink;
   assign bus1.botao_A_raw = raw_a;
   assign bus1.botao_B_raw = raw_b;
   assign bus1.ack_A       = ack_a;
   assign bus1.ack_B       = ack_b;
   assign bus1.clk_blinker = blink;

   condicionador_botoes #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(8), .ATIVO_BAIXO(1'b1)) u_dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave));
   condicionador_botoes #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(0), .ATIVO_BAIXO(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));

   logic [7:0] got0, got1;
   assign got0 = {bus0.botao_A, bus0.botao_B, bus0.pulso_A, bus0.pulso_B,
                  bus0.pedido_A, bus0.pedido_B, bus0.led_espera_A, bus0.led_espera_B};
   assign got1 = {bus1.botao_A, bus1.botao_B, bus1.pulso_A, bus1.pulso_B,
                  bus1.pedido_A, bus1.pedido_B, bus1.led_espera_A, bus1.led_espera_B};

   // Reference model: a level is accepted after DEB consecutive differing samples.
   int unsigned lock_len [2] = '{8, 0};
   bit m_s1 [2][2], m_s2 [2][2], m_deb [2][2], m_pulso [2][2], m_pedido [2][2];
   int m_run [2][2], m_lock [2][2];
   bit m_b1, m_b2;

   function automatic void model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 2; c++) begin
            m_s1[d][c] = 0; m_s2[d][c] = 0; m_deb[d][c] = 0; m_pulso[d][c] = 0;
            m_pedido[d][c] = 0; m_run[d][c] = 0; m_lock[d][c] = 0;
         end
      m_b1 = 0; m_b2 = 0;
   endfunction

   function automatic void model_edge();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 2; c++) begin
            bit pressed, ack, pulso_o, pedido_o, nova;
            int lock_o;
            pressed  = (c == 0) ? ~raw_a : ~raw_b;
            ack      = (c == 0) ? ack_a : ack_b;
            pulso_o  = m_pulso[d][c];
            pedido_o = m_pedido[d][c];
            lock_o   = m_lock[d][c];
            nova = 0;
            if (m_s2[d][c] != m_deb[d][c]) m_run[d][c]++;
            else m_run[d][c] = 0;
            if (m_run[d][c] == int'(DEB)) begin
               m_deb[d][c] = ~m_deb[d][c];
               m_run[d][c] = 0;
               nova = m_deb[d][c];
            end
            m_pulso[d][c] = nova;
            if (pulso_o && lock_o == 0) m_pedido[d][c] = 1;
            else if (ack)               m_pedido[d][c] = 0;
            if (ack && pedido_o)  m_lock[d][c] = int'(lock_len[d]);
            else if (lock_o > 0)  m_lock[d][c] = lock_o - 1;
            m_s2[d][c] = m_s1[d][c];
            m_s1[d][c] = pressed;
         end
      m_b2 = m_b1;
      m_b1 = blink;
   endfunction

   function automatic logic [7:0] exp_vec(input int d);
      return {m_deb[d][0], m_deb[d][1], m_pulso[d][0], m_pulso[d][1],
              m_pedido[d][0], m_pedido[d][1],
              m_pedido[d][0] & m_b2, m_pedido[d][1] & m_b2};
   endfunction

   task automatic check_all(input string nm);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] e, g;
         e = exp_vec(d);
         g = (d == 0) ? got0 : got1;
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL %s dut%0d outputs got=%b exp=%b at %0t", nm, d, g, e, $time);
         end
      end
   endtask

   task automatic check_bit(input string nm, input logic g, input logic e);
      vectors++;
      if (g !== e) begin
         miscompares++;
         $display("FAIL %s got=%b exp=%b at %0t", nm, g, e, $time);
      end
   endtask

   task automatic step(input string nm);
      @(posedge clk);
      model_edge();
      #1;
      check_all(nm);
   endtask

   task automatic steps(input int n, input string nm);
      for (int i = 0; i < n; i++) step(nm);
   endtask

   // Async reset between edges; outputs must clear without a clock edge.
   task automatic pulse_reset(input string nm);
      #1 reset = 1'b1;
      model_reset();
      #1;
      check_all(nm);
      check_bit({nm, "_zero0"}, got0 == 8'h00, 1'b1);
      check_bit({nm, "_zero1"}, got1 == 8'h00, 1'b1);
      #2 reset = 1'b0;
   endtask

   typedef struct {
      logic raw_a;
      logic ack_a;
      logic botao_a;
      logic pulso_a;
      logic pedido_a;
   } vec_t;

   vec_t tabela [NVEC];
   logic blink_hist [$];
   int   hold_a, hold_b;

   initial begin
      // Clean press, hold, ack and release on DUT0 (edges counted from the raw edge).
      tabela[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tabela[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tabela[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tabela[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tabela[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tabela[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tabela[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tabela[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tabela[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tabela[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tabela[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tabela[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tabela[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tabela[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tabela[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tabela[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      raw_a = 1'b1; raw_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0; blink = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("reset");
      check_bit("reset_zero0", got0 == 8'h00, 1'b1);
      #3 reset = 1'b0;
      steps(5, "idle");

      for (int i = 0; i < int'(NVEC); i++) begin
         raw_a = tabela[i].raw_a;
         ack_a = tabela[i].ack_a;
         step("tab");
         check_bit($sformatf("tab%0d_botao", i),  bus0.botao_A,  tabela[i].botao_a);
         check_bit($sformatf("tab%0d_pulso", i),  bus0.pulso_A,  tabela[i].pulso_a);
         check_bit($sformatf("tab%0d_pedido", i), bus0.pedido_A, tabela[i].pedido_a);
         check_bit($sformatf("tab%0d_pedidoB", i), bus0.pedido_B, 1'b0);
      end
      steps(6, "settle");

      // Press bounce: only the stable tail (from step 12) qualifies, pulse at step 17.
      for (int i = 0; i < 24; i++) begin
         raw_a = (i >= 12) ? 1'b0 : logic'(((i / 2) % 2) != 0);
         step("bounce_press");
         check_bit($sformatf("bounce_pulso%0d", i), bus0.pulso_A, logic'(i == 17));
      end
      // Release bounce never produces a pulse.
      for (int i = 0; i < 20; i++) begin
         raw_a = (i >= 12) ? 1'b1 : logic'(((i / 2) % 2) == 0);
         step("bounce_release");
         check_bit("bounce_rel_pulso", bus0.pulso_A, 1'b0);
      end

      // Handshake and lockout: ack at edge E, press qualifies at E+3.
      raw_a = 1'b0;
      steps(2, "lock_pre");
      ack_a = 1'b1;
      step("lock_ack");
      ack_a = 1'b0;
      check_bit("ack_clears0", bus0.pedido_A, 1'b0);
      check_bit("ack_clears1", bus1.pedido_A, 1'b0);
      steps(3, "lock_wait");
      check_bit("lock_pulso0", bus0.pulso_A, 1'b1);
      check_bit("lock_pedido0", bus0.pedido_A, 1'b0);
      step("lock_after");
      check_bit("lock_dropped0", bus0.pedido_A, 1'b0);
      check_bit("nolock_set1", bus1.pedido_A, 1'b1);
      raw_a = 1'b1;
      steps(8, "lock_release");
      raw_a = 1'b0;
      steps(7, "lock_expired");
      check_bit("post_lock_set0", bus0.pedido_A, 1'b1);

      // ack on the same cycle as the press pulse: press wins (lockout inactive).
      ack_a = 1'b1;
      step("sim_clear");
      ack_a = 1'b0;
      raw_a = 1'b1;
      steps(10, "sim_release");
      raw_a = 1'b0;
      steps(6, "sim_press");
      check_bit("sim_pulso1", bus1.pulso_A, 1'b1);
      ack_a = 1'b1;
      step("sim_ack");
      ack_a = 1'b0;
      check_bit("sim_wins1", bus1.pedido_A, 1'b1);
      check_bit("sim_wins0", bus0.pedido_A, 1'b1);
      step("sim_hold");
      check_bit("sim_hold1", bus1.pedido_A, 1'b1);

      // A and B pressed together set both requests on the same edge.
      ack_a = 1'b1; ack_b = 1'b1;
      step("ab_clear");
      ack_a = 1'b0; ack_b = 1'b0;
      raw_a = 1'b1; raw_b = 1'b1;
      steps(12, "ab_release");
      raw_a = 1'b0; raw_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step("ab_press");
         check_bit($sformatf("ab_pedA%0d", i), bus0.pedido_A, logic'(i >= 6));
         check_bit($sformatf("ab_pedB%0d", i), bus0.pedido_B, logic'(i >= 6));
      end

      // LED B follows the blink source two edges late while the request is pending.
      blink_hist.delete();
      for (int k = 0; k < 40; k++) begin
         blink = logic'(((k / 10) % 2) != 0);
         blink_hist.push_back(blink);
         step("led");
         if (k >= 2) check_bit($sformatf("led_B%0d", k), bus0.led_espera_B, blink_hist[k - 1]);
      end
      blink = 1'b1;
      steps(3, "led_high");
      ack_b = 1'b1;
      step("led_ack");
      ack_b = 1'b0;
      check_bit("led_off_after_ack", bus0.led_espera_B, 1'b0);
      step("led_off");

      // Async reset two cycles into CONF_PRESS with the button held throughout.
      raw_a = 1'b1;
      steps(8, "rst_release");
      raw_a = 1'b0;
      steps(4, "rst_conf");
      pulse_reset("rst_mid");
      for (int i = 0; i < 9; i++) begin
         step("rst_requal");
         check_bit($sformatf("rst_pulso%0d", i), bus0.pulso_A, logic'(i == 5));
         check_bit($sformatf("rst_pedido%0d", i), bus0.pedido_A, logic'(i >= 6));
      end

      // Random stimulus against the model, with mixed bounce and stable holds.
      hold_a = 0; hold_b = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hold_a == 0) begin raw_a = logic'($urandom_range(0, 1)); hold_a = $urandom_range(1, 14); end
         if (hold_b == 0) begin raw_b = logic'($urandom_range(0, 1)); hold_b = $urandom_range(1, 14); end
         hold_a--; hold_b--;
         ack_a = logic'($urandom_range(0, 11) == 0);
         ack_b = logic'($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 7) == 0) blink = ~blink;
         step("rand");
         if ($urandom_range(0, 499) == 0) pulse_reset("rand_reset");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
